// File: rtl/simon_pkg.sv
// Shared types, round constants and parameter helpers for the Simon block cipher core.
package simon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Bit i of each constant is element z[i] of the published sequence.
    localparam logic [61:0] Z2 = 62'b11001101101001111110001000010100011001001011000000111011110101;
    localparam logic [61:0] Z3 = 62'b11110000101100111001010001001000000111101001100011010111011011;
    localparam logic [61:0] Z4 = 62'b11110111001001010011000011101000000100011011010110011110001011;

    function automatic bit simon_pair_ok(input int unsigned n, input int unsigned m);
        return ((n == 32) && ((m == 3) || (m == 4))) ||
               ((n == 64) && ((m == 2) || (m == 3) || (m == 4)));
    endfunction

    function automatic int unsigned simon_rounds(input int unsigned n, input int unsigned m);
        if (n == 32 && m == 4) return 44;
        if (n == 64 && m == 2) return 68;
        if (n == 64 && m == 3) return 69;
        if (n == 64 && m == 4) return 72;
        return 42;
    endfunction

    function automatic logic [61:0] simon_z(input int unsigned n, input int unsigned m);
        if (n == 32 && m == 4) return Z3;
        if (n == 64 && m == 3) return Z3;
        if (n == 64 && m == 4) return Z4;
        return Z2;
    endfunction

endpackage

// File: rtl/simon_round.sv
// One combinational Simon round, forward (encrypt) or inverse (decrypt).
module simon_round #(
    parameter int unsigned N = 64
) (
    input  logic [N-1:0] i_x,
    input  logic [N-1:0] i_y,
    input  logic [N-1:0] i_k,
    input  logic         i_decrypt,
    output logic [N-1:0] o_x,
    output logic [N-1:0] o_y
);

    function automatic logic [N-1:0] rol(input logic [N-1:0] v, input int unsigned s);
        return (v << s) | (v >> (N - s));
    endfunction

    function automatic logic [N-1:0] simon_f(input logic [N-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    always_comb begin
        o_x = i_y ^ simon_f(i_x) ^ i_k;
        o_y = i_x;
        if (i_decrypt) begin
            o_x = i_y;
            o_y = i_x ^ simon_f(i_y) ^ i_k;
        end
    end

endmodule

// File: rtl/simon_core_param.sv
// Iterative Simon core: one round key or one cipher round per cycle, with a cached key schedule.
module simon_core_param
    import simon_pkg::*;
#(
    parameter int unsigned N = 64,
    parameter int unsigned M = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             decrypt_i,
    input  logic             new_key_i,
    input  logic [M*N-1:0]   key_i,
    input  logic [2*N-1:0]   blk_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [2*N-1:0]   blk_o
);

    localparam int unsigned T    = simon_rounds(N, M);
    localparam int unsigned CW   = $clog2(T);
    localparam logic [61:0] ZSEQ = simon_z(N, M);

    if (!simon_pair_ok(N, M)) begin : g_bad_pair
        $error("simon_core_param: unsupported (N,M) parameter pair");
    end

    function automatic logic [N-1:0] ror(input logic [N-1:0] v, input int unsigned s);
        return (v >> s) | (v << (N - s));
    endfunction

    state_t          r_state, w_state_next;
    logic            w_accept, w_last;
    logic [CW-1:0]   r_cnt;
    logic            r_key_valid, r_decrypt, r_in_ready, r_out_valid;
    logic [M*N-1:0]  r_key;
    logic [N-1:0]    r_x, r_y;
    logic [2*N-1:0]  r_blk_o;
    logic [N-1:0]    r_store [T];
    logic [N-1:0]    w_rk_new, w_rk_run, w_tmp, w_x_next, w_y_next;
    logic [CW-1:0]   w_ki, w_zi_full;
    logic [5:0]      w_zi;

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign blk_o       = r_blk_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = (r_cnt == CW'(T - 1));
        case (r_state)
            IDLE: begin
                if (in_valid_i) begin
                    w_accept     = 1'b1;
                    w_state_next = (new_key_i || !r_key_valid) ? KEYEXP : RUN;
                end
            end
            KEYEXP:  if (w_last) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    if (out_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Next round key: the first M entries are the raw key words, the rest follow the schedule recurrence.
    always_comb begin
        w_ki      = r_cnt - CW'(M);
        w_zi_full = (w_ki >= CW'(62)) ? (w_ki - CW'(62)) : w_ki;
        w_zi      = 6'(w_zi_full);
        w_tmp     = ror(r_store[r_cnt - CW'(1)], 3);
        if (M == 4) w_tmp = w_tmp ^ r_store[w_ki + CW'(1)];
        w_tmp     = w_tmp ^ ror(w_tmp, 1);
        w_rk_new  = ~r_store[w_ki] ^ w_tmp ^ N'(ZSEQ[w_zi]) ^ N'(3);
        if (r_cnt < CW'(M)) w_rk_new = N'(r_key >> (N * r_cnt));
    end

    assign w_rk_run = r_store[r_decrypt ? (CW'(T - 1) - r_cnt) : r_cnt];

    simon_round #(.N(N)) u_round (
        .i_x       (r_x),
        .i_y       (r_y),
        .i_k       (w_rk_run),
        .i_decrypt (r_decrypt),
        .o_x       (w_x_next),
        .o_y       (w_y_next)
    );

    // Key store is deliberately left out of reset; the valid flag guards it.
    always_ff @(posedge clk) begin
        if (r_state == KEYEXP) r_store[r_cnt] <= w_rk_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
            r_decrypt   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_key       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_blk_o     <= '0;
        end else begin
            r_in_ready  <= (w_state_next == IDLE);
            r_out_valid <= (w_state_next == DONE);
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (w_accept) begin
                        r_key     <= key_i;
                        r_decrypt <= decrypt_i;
                        r_x       <= blk_i[2*N-1:N];
                        r_y       <= blk_i[N-1:0];
                    end
                end
                KEYEXP: begin
                    r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
                    if (w_last) r_key_valid <= 1'b1;
                end
                RUN: begin
                    r_cnt <= w_last ? '0 : (r_cnt + CW'(1));
                    r_x   <= w_x_next;
                    r_y   <= w_y_next;
                    if (w_last) r_blk_o <= {w_x_next, w_y_next};
                end
                default: r_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_core_param.sv
// Bench for simon_core_param: a Simon128/128 and a Simon64/128 instance checked against a behavioural model.
module tb_simon_core_param;

    localparam int TA = 68;
    localparam int TB = 44;
    localparam string Z2S = "10101111011100000011010010011000101000010001111110010110110011";
    localparam string Z3S = "11011011101011000110010111100000010010001010011100110100001111";
    localparam string Z4S = "11010001111001101011011000100000010111000011001010010011101111";

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_dec, a_nk, a_out_valid, a_out_ready;
    logic [127:0] a_key, a_blk_i, a_blk_o;
    logic         b_in_valid, b_in_ready, b_dec, b_nk, b_out_valid, b_out_ready;
    logic [127:0] b_key;
    logic [63:0]  b_blk_i, b_blk_o;

    int checks = 0;
    int errors = 0;
    bit           a_cached = 1'b0, b_cached = 1'b0;
    logic [127:0] a_cache_key = '0, b_cache_key = '0;

    simon_core_param #(.N(64), .M(2)) dut_a (
        .clk(clk), .rst(rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
        .decrypt_i(a_dec), .new_key_i(a_nk), .key_i(a_key), .blk_i(a_blk_i),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .blk_o(a_blk_o)
    );

    simon_core_param #(.N(32), .M(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .decrypt_i(b_dec), .new_key_i(b_nk), .key_i(b_key), .blk_i(b_blk_i),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .blk_o(b_blk_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n);
        logic [63:0] mask;
        logic [63:0] w;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        w    = v & mask;
        return ((w << s) | (w >> (n - s))) & mask;
    endfunction

    function automatic logic [63:0] ff(input logic [63:0] v, input int n);
        return (rotl(v, 1, n) & rotl(v, 8, n)) ^ rotl(v, 2, n);
    endfunction

    // Straight textbook Simon: full key schedule into an array, then the round loop.
    function automatic logic [127:0] simon_model(input int n, input int m, input logic [127:0] key,
                                                 input logic [127:0] blk, input bit dec);
        int t;
        string zs;
        logic [63:0] mask, x, y, tmp, nx;
        logic [63:0] k [72];
        if (n == 32) begin
            t  = (m == 3) ? 42 : 44;
            zs = (m == 3) ? Z2S : Z3S;
        end else begin
            t  = (m == 2) ? 68 : (m == 3) ? 69 : 72;
            zs = (m == 2) ? Z2S : (m == 3) ? Z3S : Z4S;
        end
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        for (int i = 0; i < m; i++) k[i] = 64'(key >> (n * i)) & mask;
        for (int i = m; i < t; i++) begin
            tmp = rotl(k[i-1], n - 3, n);
            if (m == 4) tmp = tmp ^ k[i-3];
            tmp  = tmp ^ rotl(tmp, n - 1, n);
            k[i] = (~k[i-m] ^ tmp ^ 64'(zs.getc((i - m) % 62) == 8'h31) ^ 64'd3) & mask;
        end
        x = 64'(blk >> n) & mask;
        y = 64'(blk) & mask;
        if (!dec) begin
            for (int r = 0; r < t; r++) begin
                nx = (y ^ ff(x, n) ^ k[r]) & mask;
                y  = x;
                x  = nx;
            end
        end else begin
            for (int r = t - 1; r >= 0; r--) begin
                nx = (x ^ ff(y, n) ^ k[r]) & mask;
                x  = y;
                y  = nx;
            end
        end
        return (128'(x) << n) | 128'(y);
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic op_a(input logic [127:0] key, input logic [127:0] blk, input bit dec, input bit nk,
                        input int hold, input bit poke, output logic [127:0] got);
        int k;
        int exp_lat;
        logic [127:0] use_key, exp;
        use_key     = (nk || !a_cached) ? key : a_cache_key;
        exp_lat     = (nk || !a_cached) ? 2 * TA + 1 : TA + 1;
        exp         = simon_model(64, 2, use_key, blk, dec);
        a_cached    = 1'b1;
        a_cache_key = use_key;
        @(negedge clk);
        chk("a_ready_idle", 128'(a_in_ready), 128'(1));
        a_key = key; a_blk_i = blk; a_dec = dec; a_nk = nk; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0; a_key = rnd128(); a_blk_i = rnd128(); a_dec = ~dec; a_nk = ~nk;
        k = 0;
        while (!a_out_valid && k < 400) begin
            if (poke && k == 20) a_in_valid = 1'b1;
            if (poke && k == 21) a_in_valid = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        got = a_blk_o;
        chk("a_latency", 128'(k + 1), 128'(exp_lat));
        chk("a_result", a_blk_o, exp);
        chk("a_busy_ready", 128'(a_in_ready), 128'(0));
        repeat (hold) begin
            @(posedge clk); #1;
            chk("a_hold_valid", 128'(a_out_valid), 128'(1));
            chk("a_hold_blk", a_blk_o, exp);
            chk("a_hold_ready", 128'(a_in_ready), 128'(0));
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("a_valid_drop", 128'(a_out_valid), 128'(0));
        chk("a_back_idle", 128'(a_in_ready), 128'(1));
    endtask

    task automatic op_b(input logic [127:0] key, input logic [63:0] blk, input bit dec, input bit nk,
                        output logic [63:0] got);
        int k;
        int exp_lat;
        logic [127:0] use_key, exp;
        use_key     = (nk || !b_cached) ? key : b_cache_key;
        exp_lat     = (nk || !b_cached) ? 2 * TB + 1 : TB + 1;
        exp         = simon_model(32, 4, use_key, 128'(blk), dec);
        b_cached    = 1'b1;
        b_cache_key = use_key;
        @(negedge clk);
        chk("b_ready_idle", 128'(b_in_ready), 128'(1));
        b_key = key; b_blk_i = blk; b_dec = dec; b_nk = nk; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_key = rnd128(); b_blk_i = 64'(rnd128()); b_dec = ~dec; b_nk = ~nk;
        k = 0;
        while (!b_out_valid && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        got = b_blk_o;
        chk("b_latency", 128'(k + 1), 128'(exp_lat));
        chk("b_result", 128'(b_blk_o), exp);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        chk("b_valid_drop", 128'(b_out_valid), 128'(0));
        chk("b_back_idle", 128'(b_in_ready), 128'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [127:0] got_a, ka, pa;
        logic [63:0]  got_b;
        rst = 1'b1;
        a_in_valid = 1'b0; a_dec = 1'b0; a_nk = 1'b0; a_out_ready = 1'b0; a_key = '0; a_blk_i = '0;
        b_in_valid = 1'b0; b_dec = 1'b0; b_nk = 1'b0; b_out_ready = 1'b0; b_key = '0; b_blk_i = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_ready", 128'(a_in_ready), 128'(1));
        chk("rst_a_valid", 128'(a_out_valid), 128'(0));
        chk("rst_a_blk", a_blk_o, 128'(0));
        chk("rst_b_ready", 128'(b_in_ready), 128'(1));
        chk("rst_b_valid", 128'(b_out_valid), 128'(0));
        chk("rst_b_blk", 128'(b_blk_o), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // Known-answer vectors, then cached decrypt with a stalled consumer.
        op_a(128'h0f0e0d0c0b0a09080706050403020100, 128'h63736564207372656c6c657661727420,
             1'b0, 1'b1, 0, 1'b0, got_a);
        chk("kat128_ct", got_a, 128'h49681b1e1e54fe3f65aa832af84e0bbc);
        op_a(rnd128(), 128'h49681b1e1e54fe3f65aa832af84e0bbc, 1'b1, 1'b0, 10, 1'b0, got_a);
        chk("kat128_pt", got_a, 128'h63736564207372656c6c657661727420);
        op_b(128'h1b1a1918131211100b0a090803020100, 64'h656b696c20646e75, 1'b0, 1'b1, got_b);
        chk("kat64_ct", 128'(got_b), 128'h44c8fc20b9dfa07a);

        // Random traffic; one transaction also sees a stray in_valid pulse while busy.
        for (int i = 0; i < 5; i++) begin
            ka = rnd128();
            pa = rnd128();
            op_a(ka, pa, 1'($urandom_range(0, 1)), (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                 0, (i == 2), got_a);
            if (i == 2) begin
                repeat (150) @(posedge clk);
                #1;
                chk("a_no_second_result", 128'(a_out_valid), 128'(0));
                chk("a_still_idle", 128'(a_in_ready), 128'(1));
            end
        end
        for (int i = 0; i < 4; i++) begin
            op_b(rnd128(), 64'(rnd128()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got_b);
        end

        // Reset in the middle of a cached encrypt.
        @(negedge clk);
        a_key = rnd128(); a_blk_i = rnd128(); a_dec = 1'b0; a_nk = 1'b0; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_a_valid", 128'(a_out_valid), 128'(0));
        chk("midrst_a_blk", a_blk_o, 128'(0));
        chk("midrst_a_ready", 128'(a_in_ready), 128'(1));
        a_cached = 1'b0;
        b_cached = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midrst_no_output", 128'(a_out_valid), 128'(0));
        op_a(rnd128(), rnd128(), 1'b0, 1'b0, 0, 1'b0, got_a);
        op_b(rnd128(), 64'(rnd128()), 1'b1, 1'b0, got_b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
